// File: rtl/branch_predictor.sv
// Fetch-side direct-mapped BTB with 2-bit saturating counters, EX-stage training and mispredict
// redirect. Define BPRED_GSHARE_EN to index the counters with PC XOR global history (gshare).
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module branch_predictor #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned GHR_W   = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [`PC_WIDTH-1:0] IF_PC,
    output logic                 Pred_Taken,
    output logic [`PC_WIDTH-1:0] Pred_Target,
    output logic                 Pred_Hit,
`ifdef BPRED_GSHARE_EN
    output logic [GHR_W-1:0]     IF_GHR,
    input  logic [GHR_W-1:0]     EX_GHR,
`endif
    input  logic                 EX_Branch,
    input  logic                 EX_Stall,
    input  logic [`PC_WIDTH-1:0] EX_PC,
    input  logic                 Branch_Taken,
    input  logic [`PC_WIDTH-1:0] PC_Plus_Imm,
    input  logic                 EX_Pred_Taken,
    input  logic [`PC_WIDTH-1:0] EX_Pred_Target,
    output logic                 Mispredict,
    output logic [`PC_WIDTH-1:0] Redirect_PC
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned PC_W  = `PC_WIDTH;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    // Counter table; indexed by plain PC index, or by the hashed index under gshare
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] if_cidx;
    logic [TAG_W-1:0] if_tag;
    logic [IDX_W-1:0] ex_idx;
    logic [IDX_W-1:0] ex_cidx;
    logic [TAG_W-1:0] ex_tag;

    logic             upd;
    logic             ex_hit;
    logic             ctr_we;
    logic [1:0]       ctr_d;

    assign if_idx = IF_PC[IDX_W+1:2];
    assign if_tag = IF_PC[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = EX_PC[IDX_W+1:2];
    assign ex_tag = EX_PC[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPRED_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    function automatic logic [IDX_W-1:0] fold_ghr(input logic [GHR_W-1:0] g);
        return IDX_W'(g);
    endfunction

    assign if_cidx = if_idx ^ fold_ghr(ghr_q);
    assign ex_cidx = ex_idx ^ fold_ghr(EX_GHR);
    assign IF_GHR  = ghr_q;

    // History is updated only by resolved branches, so it never needs repair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (upd) begin
            ghr_q <= {ghr_q[GHR_W-2:0], Branch_Taken};
        end
    end
`else
    logic [GHR_W-1:0] unused_ghr_w;

    assign if_cidx      = if_idx;
    assign ex_cidx      = ex_idx;
    assign unused_ghr_w = '0;
`endif

    // PC bits outside the index/tag fields do not participate in the lookup
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC, EX_PC};

    // Lookup: purely combinational, reads the pre-write table contents
    assign Pred_Hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign Pred_Taken  = Pred_Hit && ctr_q[if_cidx][1];
    assign Pred_Target = Pred_Hit ? target_q[if_idx] : '0;

    // Training
    assign upd    = EX_Branch && !EX_Stall;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign ctr_we = upd && (ex_hit || Branch_Taken);

    always_comb begin
        ctr_d = ctr_q[ex_cidx];
        if (!ex_hit) begin
            ctr_d = 2'b10;
        end else if (Branch_Taken) begin
            if (ctr_d != 2'b11) begin
                ctr_d = ctr_d + 2'd1;
            end
        end else if (ctr_d != 2'b00) begin
            ctr_d = ctr_d - 2'd1;
        end
    end

    // A taken branch either refreshes the hit entry's target or allocates over the entry;
    // rewriting valid/tag on a hit leaves them unchanged, so both cases share one write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (upd && Branch_Taken) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= PC_Plus_Imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (ctr_we) begin
            ctr_q[ex_cidx] <= ctr_d;
        end
    end

    // Resolution
    assign Mispredict  = rst_n && EX_Branch &&
                         ((Branch_Taken != EX_Pred_Taken) ||
                          (Branch_Taken && (EX_Pred_Target != PC_Plus_Imm)));
    assign Redirect_PC = Branch_Taken ? PC_Plus_Imm : EX_PC + PC_W'(4);

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural BTB model queues expected outputs per
// cycle and a negedge monitor compares them against the DUT.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif

module tb_branch_predictor;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned IDX_W   = $clog2(ENTRIES);
    localparam int unsigned PW      = `PC_WIDTH;

    typedef logic [PW-1:0] pc_t;

    typedef struct {
        string name;
        logic  hit;
        logic  tk;
        pc_t   tgt;
        logic  mis;
        pc_t   red;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    pc_t  IF_PC, EX_PC, PC_Plus_Imm, EX_Pred_Target;
    logic EX_Branch, EX_Stall, Branch_Taken, EX_Pred_Taken;
    logic Pred_Taken, Pred_Hit, Mispredict;
    pc_t  Pred_Target, Redirect_PC;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .GHR_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IF_PC          (IF_PC),
        .Pred_Taken     (Pred_Taken),
        .Pred_Target    (Pred_Target),
        .Pred_Hit       (Pred_Hit),
        .EX_Branch      (EX_Branch),
        .EX_Stall       (EX_Stall),
        .EX_PC          (EX_PC),
        .Branch_Taken   (Branch_Taken),
        .PC_Plus_Imm    (PC_Plus_Imm),
        .EX_Pred_Taken  (EX_Pred_Taken),
        .EX_Pred_Target (EX_Pred_Target),
        .Mispredict     (Mispredict),
        .Redirect_PC    (Redirect_PC)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    // Reference model: one record per BTB slot, counters as plain integers 0..3
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    pc_t         m_target [ENTRIES];
    int          m_ctr    [ENTRIES];

    function automatic int unsigned idx_of(pc_t pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    function automatic int unsigned tag_of(pc_t pc);
        return (pc >> (IDX_W + 2)) % (1 << TAG_W);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 1;
        end
    endfunction

    function automatic bit model_hit(pc_t pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic void model_train(pc_t pc, bit tk, pc_t imm);
        int unsigned i = idx_of(pc);
        if (model_hit(pc)) begin
            if (tk) begin
                m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_target[i] = imm;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = tag_of(pc);
            m_target[i] = imm;
            m_ctr[i]    = 2;
        end
    endfunction

    function automatic void chk(string name, string field, pc_t act, pc_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s: got %h expected %h", name, field, act, exp);
        end
    endfunction

    exp_t e_mon;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            chk(e_mon.name, "Pred_Hit",    pc_t'(Pred_Hit),   pc_t'(e_mon.hit));
            chk(e_mon.name, "Pred_Taken",  pc_t'(Pred_Taken), pc_t'(e_mon.tk));
            chk(e_mon.name, "Pred_Target", Pred_Target,       e_mon.tgt);
            chk(e_mon.name, "Mispredict",  pc_t'(Mispredict), pc_t'(e_mon.mis));
            chk(e_mon.name, "Redirect_PC", Redirect_PC,       e_mon.red);
        end
    end

    task automatic step(string name, pc_t if_pc, bit br, bit stall, pc_t ex_pc, bit tk,
                        pc_t imm, bit ptk, pc_t ptgt);
        exp_t e;
        int unsigned i;
        @(posedge clk);
        #1;
        IF_PC          = if_pc;
        EX_Branch      = br;
        EX_Stall       = stall;
        EX_PC          = ex_pc;
        Branch_Taken   = tk;
        PC_Plus_Imm    = imm;
        EX_Pred_Taken  = ptk;
        EX_Pred_Target = ptgt;
        i      = idx_of(if_pc);
        e.name = name;
        e.hit  = model_hit(if_pc);
        e.tk   = e.hit && (m_ctr[i] >= 2);
        e.tgt  = e.hit ? m_target[i] : '0;
        e.mis  = br && ((tk != ptk) || (tk && (ptgt != imm)));
        e.red  = tk ? imm : ex_pc + 4;
        sb.push_back(e);
        if (br && !stall) model_train(ex_pc, tk, imm);
    endtask

    task automatic lookup(string name, pc_t if_pc);
        step(name, if_pc, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    // Reset dropped mid-cycle while a taken, allocating branch is being trained
    task automatic async_reset_step();
        exp_t e;
        @(posedge clk);
        #1;
        IF_PC          = 'h300;
        EX_Branch      = 1'b1;
        EX_Stall       = 1'b0;
        EX_PC          = 'h300;
        Branch_Taken   = 1'b1;
        PC_Plus_Imm    = 'h380;
        EX_Pred_Taken  = 1'b0;
        EX_Pred_Target = '0;
        #2;
        rst_n  = 1'b0;
        model_reset();
        e.name = "async_rst";
        e.hit  = 1'b0;
        e.tk   = 1'b0;
        e.tgt  = '0;
        e.mis  = 1'b0;
        e.red  = 'h380;
        sb.push_back(e);
        @(posedge clk);
        #1;
        EX_Branch = 1'b0;
        rst_n     = 1'b1;
    endtask

    function automatic pc_t rand_pc();
        pc_t p;
        p = pc_t'($urandom_range(0, 2)) << (IDX_W + 2);
        p = p | (pc_t'($urandom_range(0, 5)) << 2) | pc_t'($urandom_range(0, 3));
        p = p | (pc_t'($urandom_range(0, 1)) << 20);
        return p;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        pc_t a, b, imm, ptgt;
        rst_n          = 1'b0;
        IF_PC          = '0;
        EX_Branch      = 1'b0;
        EX_Stall       = 1'b0;
        EX_PC          = '0;
        Branch_Taken   = 1'b0;
        PC_Plus_Imm    = '0;
        EX_Pred_Taken  = 1'b0;
        EX_Pred_Target = '0;
        model_reset();
        #23 rst_n = 1'b1;

        lookup("reset_lookup", 'h100);
        step("alloc", 'h100, 1, 0, 'h100, 1, 'h180, 0, '0);
        lookup("after_alloc", 'h100);
        for (int k = 0; k < 3; k++) step("not_taken", 'h100, 1, 0, 'h100, 0, 'h180, 0, '0);
        lookup("saturated_low", 'h100);
        for (int k = 0; k < 3; k++) step("stalled", 'h100, 1, 1, 'h100, 1, 'h180, 1, 'h1C0);
        step("unstalled", 'h100, 1, 0, 'h100, 1, 'h180, 1, 'h1C0);
        lookup("train_once", 'h100);
        step("retrain", 'h100, 1, 0, 'h100, 1, 'h180, 0, '0);
        lookup("retrained", 'h103);
        step("alias", 'h0, 1, 0, 'h100 + 4 * ENTRIES, 1, 'h280, 0, '0);
        lookup("aliased_out", 'h100);
        lookup("alias_hit", 'h100 + 4 * ENTRIES);
        step("wrap", 'h0, 1, 0, 'hFFFF_FFFC, 0, 'h40, 1, 'h40);
        step("no_branch", 'h0, 0, 0, 'h100, 1, 'h999, 0, '0);
        async_reset_step();
        lookup("post_rst_a", 'h300);
        lookup("post_rst_b", 'h100 + 4 * ENTRIES);

        for (int n = 0; n < 400; n++) begin
            a    = rand_pc();
            b    = rand_pc();
            imm  = pc_t'(32'h1000 + 4 * $urandom_range(0, 3));
            ptgt = ($urandom_range(0, 1) == 1) ? imm : pc_t'(32'h1000 + 4 * $urandom_range(0, 3));
            step("rand", a, $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0, b,
                 $urandom_range(0, 1) == 1, imm, $urandom_range(0, 1) == 1, ptgt);
        end

        repeat (5) @(posedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expected entries left, 0 required", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side dynamic branch predictor: direct-mapped BTB with per-entry 2-bit saturating counters.
- Looks up IF_PC in the same cycle and supplies predicted direction and target to the PC-select mux.
- Trained at the EX end by the resolved branch (taken flag, target) from the EX branch-resolution logic.
- Generates the mispredict flush and the corrected redirect PC.

Parameters:
- ENTRIES, 64, BTB entries (power of 2, ≥4); IDX_W = log2(ENTRIES).
- TAG_W, 8, tag bits taken from PC above the index field.
- GHR_W, 6, global history length (used only with BPRED_GSHARE_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IF_PC  in  `PC_WIDTH  fetch PC to predict.
- Pred_Taken  out  1  predicted taken.
- Pred_Target  out  `PC_WIDTH  predicted target; valid when Pred_Taken=1.
- Pred_Hit  out  1  BTB tag hit for IF_PC.
- EX_Branch  in  1  EX holds a conditional branch.
- EX_Stall  in  1  EX stalled; suppresses training.
- EX_PC  in  `PC_WIDTH  PC of the EX branch.
- Branch_Taken  in  1  resolved direction.
- PC_Plus_Imm  in  `PC_WIDTH  resolved branch target.
- EX_Pred_Taken  in  1  Pred_Taken carried down the pipeline with this branch.
- EX_Pred_Target  in  `PC_WIDTH  Pred_Target carried down the pipeline.
- Mispredict  out  1  flush IF/ID, redirect fetch.
- Redirect_PC  out  `PC_WIDTH  correct next PC.

Behaviour:
- Address fields:
  - idx = PC[IDX_W+1:2].
  - tag = PC[IDX_W+TAG_W+1:IDX_W+2].
  - PC[1:0] ignored.
- Entry contents: valid, tag, target[`PC_WIDTH], ctr[1:0].
- Reset (async, rst_n=0):
  - All valid=0, ctr=2'b01, target=0, tag=0.
  - Outputs: Pred_Hit=0, Pred_Taken=0, Pred_Target=0, Mispredict=0.
  - Redirect_PC follows its combinational equation.
  - Reset asserted mid-training: the pending write is dropped.
- Lookup (combinational, 0-cycle latency):
  - Pred_Hit = valid[idx] && tag match.
  - Pred_Taken = Pred_Hit && ctr[idx][1].
  - Pred_Target = Pred_Hit ? target[idx] : 0.
- Training: occurs at the rising edge when upd = EX_Branch && !EX_Stall.
  - Hit:
    - Taken: ctr saturating +1 (max 2'b11), target <= PC_Plus_Imm.
    - Not taken: ctr saturating −1 (min 2'b00), target unchanged.
  - Miss and taken: allocate (overwrite) the entry with valid=1, tag, target=PC_Plus_Imm, ctr=2'b10.
  - Miss and not taken: no write.
- Read/write same index in the same cycle: lookup returns the pre-write value (no bypass); the new value is visible the next cycle.
- Mispredict (combinational) = EX_Branch && ((Branch_Taken != EX_Pred_Taken) || (Branch_Taken && EX_Pred_Target != PC_Plus_Imm)).
- Redirect_PC = Branch_Taken ? PC_Plus_Imm : EX_PC + 4 (modulo 2^`PC_WIDTH, wrap allowed).
- A stalled EX branch may assert Mispredict every stalled cycle; training happens exactly once, on the non-stalled cycle.
- EX_Branch=0 forces Mispredict=0; the table is untouched.

Optional Feature:
- Macro: BPRED_GSHARE_EN.
- Defined:
  - GHR_W-bit global history register, reset to 0.
  - Counter index = idx XOR {zero-extended/truncated GHR to IDX_W}. Tag and target still use the plain PC idx; counters move to a separate ENTRIES-deep PHT.
  - Extra ports: IF_GHR out GHR_W (current GHR, carried down the pipeline); EX_GHR in GHR_W.
  - Training PHT index uses EX_GHR.
  - On each upd, GHR <= {GHR[GHR_W-2:0], Branch_Taken}. History is non-speculative.
  - PHT counters reset to 2'b01.
  - Pred_Taken = Pred_Hit && pht[gidx][1].
- Undefined: no GHR, no extra ports, per-entry counters as above.

Test Plan:
- Reset, then IF_PC=0x100 → Pred_Hit=0, Pred_Taken=0, Pred_Target=0.
- EX_Branch=1, EX_PC=0x100, Branch_Taken=1, PC_Plus_Imm=0x180, EX_Pred_Taken=0 → Mispredict=1, Redirect_PC=0x180. Next cycle IF_PC=0x100 → Pred_Hit=1, Pred_Taken=1, Pred_Target=0x180.
- Three not-taken resolutions of 0x100 after allocation: ctr 10→01→00→00 (saturates). Pred_Taken=0 after the first. Mispredict=0 when EX_Pred_Taken=0; Redirect_PC=0x104.
- Aliasing: allocate 0x100, then taken branch at 0x100+4·ENTRIES → entry overwritten; lookup of 0x100 gives Pred_Hit=0.
- EX_Stall=1 for 3 cycles with a taken branch held → ctr changes once only; target mismatch (EX_Pred_Target=0x1C0, PC_Plus_Imm=0x180) → Mispredict=1.
- rst_n dropped asynchronously mid-cycle with upd=1 → outputs clear immediately; no entry valid afterwards.
